// File: rtl/cameralink_pkg.sv
// Shared constants for the Camera Link Medium transmit framer:
// pixel/word geometry, control-bit positions and FSM state encodings.
package cameralink_pkg;

    localparam int PIX_W        = 12;
    localparam int PIX_PER_BEAT = 4;
    localparam int BEAT_W       = PIX_W * PIX_PER_BEAT;
    localparam int WORD_W       = 28;

    localparam int SPARE_BIT = 23;
    localparam int LVAL_BIT  = 24;
    localparam int FVAL_BIT  = 25;
    localparam int DVAL_BIT  = 26;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HBLANK = 2'd1;
    localparam state_t ST_ACTIVE = 2'd2;
    localparam state_t ST_VBLANK = 2'd3;

endpackage

// File: rtl/cameralink_bit_mapper.sv
// Packs two 12-bit pixels plus LVAL/FVAL/DVAL into one 28-bit serializer word;
// the bit placement is the exact inverse of the receiver port extraction.
module cameralink_bit_mapper
    import cameralink_pkg::*;
(
    input  logic [PIX_W-1:0]  px_lo,
    input  logic [PIX_W-1:0]  px_hi,
    input  logic              lval,
    input  logic              fval,
    input  logic              dval,
    output logic [WORD_W-1:0] word
);

    logic [7:0] port_a_s;
    logic [7:0] port_b_s;
    logic [7:0] port_c_s;

    assign port_a_s = px_lo[7:0];
    assign port_b_s = {px_hi[3:0], px_lo[11:8]};
    assign port_c_s = px_hi[11:4];

    // Scatter port bits and control flags onto the serializer word
    always_comb begin
        word             = {WORD_W{1'b0}};
        word[5]          = port_a_s[7];
        word[27]         = port_a_s[6];
        word[6]          = port_a_s[5];
        word[4:0]        = port_a_s[4:0];
        word[11]         = port_b_s[7];
        word[10]         = port_b_s[6];
        word[14:12]      = port_b_s[5:3];
        word[9:7]        = port_b_s[2:0];
        word[17]         = port_c_s[7];
        word[16]         = port_c_s[6];
        word[22:18]      = port_c_s[5:1];
        word[15]         = port_c_s[0];
        word[SPARE_BIT]  = 1'b0;
        word[LVAL_BIT]   = lval;
        word[FVAL_BIT]   = fval;
        word[DVAL_BIT]   = dval;
    end

endmodule

// File: rtl/cameralink_medium_tx_framer.sv
// Camera Link Medium transmit framer: FVAL/LVAL/DVAL timing plus port A-F mapping.
// Optional built-in test-pattern generator enabled by `define CLINK_TEST_PATTERN_EN.
module cameralink_medium_tx_framer
    import cameralink_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 64,
    parameter int CNT_W    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              enable_i,
    input  logic [BEAT_W-1:0] pixel_data_i,
    input  logic              pixel_vld_i,
    output logic              pixel_rdy_o,
    input  logic              test_mode_i,
    output logic [WORD_W-1:0] tx_1_o,
    output logic [WORD_W-1:0] tx_2_o,
    output logic              frame_start_o,
    output logic [15:0]       underrun_cnt_o
);

    localparam logic [CNT_W-1:0] H_ACTIVE_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_BLANK_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] V_ACTIVE_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_BLANK_LAST  = CNT_W'(V_BLANK - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   col_cnt_r;
    logic [CNT_W-1:0]   line_cnt_r;
    logic [CNT_W-1:0]   blank_cnt_r;
    logic               start_s;
    logic               active_s;
    logic               accept_s;
    logic               starve_s;
    logic               gen_mode_s;
    logic               fval_s;
    logic [BEAT_W-1:0]  beat_src_s;
    logic [BEAT_W-1:0]  beat_s;
    logic [WORD_W-1:0]  word_1_s;
    logic [WORD_W-1:0]  word_2_s;
    logic [WORD_W-1:0]  tx_1_r;
    logic [WORD_W-1:0]  tx_2_r;
    logic               frame_start_r;
    logic [15:0]        underrun_r;

`ifdef CLINK_TEST_PATTERN_EN
    logic               test_mode_r;
    logic [PIX_W-1:0]   frame_cnt_r;
    logic [PIX_W-1:0]   frame_base_r;
    logic [PIX_W-1:0]   pat_base_s;

    assign gen_mode_s = test_mode_r;
    assign pat_base_s = PIX_W'({col_cnt_r, 2'b00}) + PIX_W'(line_cnt_r) + frame_base_r;
    assign beat_src_s = test_mode_r ? {pat_base_s + 12'd3, pat_base_s + 12'd2,
                                       pat_base_s + 12'd1, pat_base_s}
                                    : pixel_data_i;

    // Latch the mode and the pattern offset for the frame that is starting
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            test_mode_r  <= 1'b0;
            frame_cnt_r  <= 12'd0;
            frame_base_r <= 12'd0;
        end else if (start_s) begin
            test_mode_r  <= test_mode_i;
            frame_base_r <= frame_cnt_r;
            frame_cnt_r  <= frame_cnt_r + 12'd1;
        end
    end
`else
    logic unused_test_mode_s;

    assign unused_test_mode_s = test_mode_i;
    assign gen_mode_s         = 1'b0;
    assign beat_src_s         = pixel_data_i;
`endif

    assign active_s    = (state_r == ST_ACTIVE);
    assign accept_s    = active_s && (gen_mode_s || pixel_vld_i);
    assign starve_s    = active_s && !accept_s;
    assign fval_s      = (state_r == ST_HBLANK) || active_s;
    assign beat_s      = accept_s ? beat_src_s : {BEAT_W{1'b0}};
    assign pixel_rdy_o = active_s && !gen_mode_s;

    // Frame-timing next-state; enable_i only matters at frame boundaries
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) begin
                    state_nxt_s = ST_HBLANK;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HBLANK: begin
                if (blank_cnt_r == H_BLANK_LAST) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_HBLANK;
                end
            end
            ST_ACTIVE: begin
                if (accept_s && (col_cnt_r == H_ACTIVE_LAST)) begin
                    if (line_cnt_r == V_ACTIVE_LAST) begin
                        state_nxt_s = ST_VBLANK;
                    end else begin
                        state_nxt_s = ST_HBLANK;
                    end
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_VBLANK: begin
                if (blank_cnt_r == V_BLANK_LAST) begin
                    if (enable_i) begin
                        state_nxt_s = ST_HBLANK;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_VBLANK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Column, line and blanking counters; the column moves only on acceptance
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_cnt_r   <= {CNT_W{1'b0}};
            line_cnt_r  <= {CNT_W{1'b0}};
            blank_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_HBLANK: begin
                    if (blank_cnt_r == H_BLANK_LAST) begin
                        blank_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        blank_cnt_r <= blank_cnt_r + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (accept_s) begin
                        if (col_cnt_r == H_ACTIVE_LAST) begin
                            col_cnt_r <= {CNT_W{1'b0}};
                            if (line_cnt_r == V_ACTIVE_LAST) begin
                                line_cnt_r <= {CNT_W{1'b0}};
                            end else begin
                                line_cnt_r <= line_cnt_r + 1'b1;
                            end
                        end else begin
                            col_cnt_r <= col_cnt_r + 1'b1;
                        end
                    end
                end
                ST_VBLANK: begin
                    if (blank_cnt_r == V_BLANK_LAST) begin
                        blank_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        blank_cnt_r <= blank_cnt_r + 1'b1;
                    end
                end
                default: begin
                    col_cnt_r   <= {CNT_W{1'b0}};
                    line_cnt_r  <= {CNT_W{1'b0}};
                    blank_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    cameralink_bit_mapper u_map_ch1 (
        .px_lo (beat_s[11:0]),
        .px_hi (beat_s[23:12]),
        .lval  (active_s),
        .fval  (fval_s),
        .dval  (accept_s),
        .word  (word_1_s)
    );

    cameralink_bit_mapper u_map_ch2 (
        .px_lo (beat_s[35:24]),
        .px_hi (beat_s[47:36]),
        .lval  (active_s),
        .fval  (fval_s),
        .dval  (accept_s),
        .word  (word_2_s)
    );

    // Output words, frame-start pulse and saturating underrun counter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_1_r        <= {WORD_W{1'b0}};
            tx_2_r        <= {WORD_W{1'b0}};
            frame_start_r <= 1'b0;
            underrun_r    <= 16'd0;
        end else begin
            tx_1_r        <= word_1_s;
            tx_2_r        <= word_2_s;
            frame_start_r <= start_s;
            if (start_s) begin
                underrun_r <= 16'd0;
            end else if (starve_s && (underrun_r != 16'hFFFF)) begin
                underrun_r <= underrun_r + 16'd1;
            end
        end
    end

    assign tx_1_o         = tx_1_r;
    assign tx_2_o         = tx_2_r;
    assign frame_start_o  = frame_start_r;
    assign underrun_cnt_o = underrun_r;

endmodule

// File: tb/tb_cameralink_medium_tx_framer.sv
// Directed bench for the Camera Link Medium transmit framer with a small frame
// (4 beats x 3 lines, 2-cycle blanking); pattern test only with CLINK_TEST_PATTERN_EN.
module tb_cameralink_medium_tx_framer;

    localparam logic [27:0] W_ZERO = 28'h0000000;
    localparam logic [27:0] W_HB   = 28'h2000000;
    localparam logic [27:0] W_UR   = 28'h3000000;
    localparam logic [27:0] W1_D   = 28'hF246216;
    localparam logic [27:0] W2_D   = 28'hF147A3E;
    localparam logic [47:0] D0     = 48'h0AB_CDE_123_456;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic [47:0] pixel_data_i = 48'd0;
    logic        pixel_vld_i = 1'b0;
    logic        pixel_rdy_o;
    logic        test_mode_i = 1'b0;
    logic [27:0] tx_1_o;
    logic [27:0] tx_2_o;
    logic        frame_start_o;
    logic [15:0] underrun_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    cameralink_medium_tx_framer #(
        .H_ACTIVE (4),
        .H_BLANK  (2),
        .V_ACTIVE (3),
        .V_BLANK  (2),
        .CNT_W    (16)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .enable_i       (enable_i),
        .pixel_data_i   (pixel_data_i),
        .pixel_vld_i    (pixel_vld_i),
        .pixel_rdy_o    (pixel_rdy_o),
        .test_mode_i    (test_mode_i),
        .tx_1_o         (tx_1_o),
        .tx_2_o         (tx_2_o),
        .frame_start_o  (frame_start_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Receiver-side extraction: returns {px1, px0} recovered from one word
    function automatic logic [23:0] rx_px(input logic [27:0] w);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        a = {w[5], w[27], w[6], w[4:0]};
        b = {w[11], w[10], w[14:12], w[9:7]};
        c = {w[17], w[16], w[22:18], w[15]};
        return {c, b, a};
    endfunction

    // Nominal frame position k (1 = first HBLANK cycle): 1 HB, 2 ACTIVE, 3 VBLANK
    function automatic int state_of(input int k);
        int k2;
        k2 = (k - 1) % 20;
        if (k2 >= 18) return 3;
        if ((k2 % 6) < 2) return 1;
        return 2;
    endfunction

    task automatic wait_fs(input string tag);
        int t;
        t = 0;
        while (frame_start_o !== 1'b1 && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        n_cmp++;
        if (frame_start_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s wait_fs: frame_start_o=%b, required 1 within 200 cycles", tag, frame_start_o);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int t;
        t = 0;
        while (pixel_rdy_o !== 1'b1 && t < 50) begin
            @(negedge sys_clk);
            t++;
        end
        n_cmp++;
        if (pixel_rdy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s wait_rdy: pixel_rdy_o=%b, required 1 within 50 cycles", tag, pixel_rdy_o);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        enable_i  = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp += 5;
        if (tx_1_o !== W_ZERO) begin n_bad++; $display("FAIL reset tx_1: got %h want %h", tx_1_o, W_ZERO); end
        if (tx_2_o !== W_ZERO) begin n_bad++; $display("FAIL reset tx_2: got %h want %h", tx_2_o, W_ZERO); end
        if (pixel_rdy_o !== 1'b0) begin n_bad++; $display("FAIL reset rdy: got %b want 0", pixel_rdy_o); end
        if (frame_start_o !== 1'b0) begin n_bad++; $display("FAIL reset fs: got %b want 0", frame_start_o); end
        if (underrun_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset uc: got %0d want 0", underrun_cnt_o); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_cmp += 2;
        if (frame_start_o !== 1'b0) begin n_bad++; $display("FAIL idle fs: got %b want 0", frame_start_o); end
        if (tx_1_o !== W_ZERO) begin n_bad++; $display("FAIL idle tx_1: got %h want %h", tx_1_o, W_ZERO); end
    endtask

    task automatic test_frame_timing();
        logic [27:0] e1;
        logic [27:0] e2;
        enable_i     = 1'b1;
        pixel_vld_i  = 1'b1;
        pixel_data_i = D0;
        wait_fs("frame");
        for (int i = 1; i <= 20; i++) begin
            @(negedge sys_clk);
            case (state_of(i))
                1:       begin e1 = W_HB;   e2 = W_HB;   end
                2:       begin e1 = W1_D;   e2 = W2_D;   end
                default: begin e1 = W_ZERO; e2 = W_ZERO; end
            endcase
            n_cmp += 4;
            if (tx_1_o !== e1) begin n_bad++; $display("FAIL frame tx_1 @%0d: got %h want %h", i, tx_1_o, e1); end
            if (tx_2_o !== e2) begin n_bad++; $display("FAIL frame tx_2 @%0d: got %h want %h", i, tx_2_o, e2); end
            if (pixel_rdy_o !== (state_of(i + 1) == 2)) begin
                n_bad++; $display("FAIL frame rdy @%0d: got %b want %b", i, pixel_rdy_o, state_of(i + 1) == 2);
            end
            if (frame_start_o !== (i == 20)) begin
                n_bad++; $display("FAIL frame fs @%0d: got %b want %b", i, frame_start_o, i == 20);
            end
        end
        n_cmp++;
        if (underrun_cnt_o !== 16'd0) begin n_bad++; $display("FAIL frame uc: got %0d want 0", underrun_cnt_o); end
    endtask

    task automatic test_pixel_map();
        logic [47:0] pats [5];
        pats[0] = D0;
        pats[1] = 48'hFFF_FFF_FFF_FFF;
        pats[2] = 48'h800_001_555_AAA;
        pats[3] = 48'h123_456_789_ABC;
        pats[4] = 48'h000_000_000_001;
        for (int j = 0; j < 5; j++) begin
            wait_rdy("pixmap");
            pixel_data_i = pats[j];
            @(negedge sys_clk);
            n_cmp += 4;
            if (rx_px(tx_1_o) !== pats[j][23:0]) begin
                n_bad++; $display("FAIL pixmap ch1 #%0d: got %h want %h", j, rx_px(tx_1_o), pats[j][23:0]);
            end
            if (rx_px(tx_2_o) !== pats[j][47:24]) begin
                n_bad++; $display("FAIL pixmap ch2 #%0d: got %h want %h", j, rx_px(tx_2_o), pats[j][47:24]);
            end
            if (tx_1_o[26:23] !== 4'b1110) begin
                n_bad++; $display("FAIL pixmap ctl1 #%0d: got %b want 1110", j, tx_1_o[26:23]);
            end
            if (tx_2_o[26:23] !== 4'b1110) begin
                n_bad++; $display("FAIL pixmap ctl2 #%0d: got %b want 1110", j, tx_2_o[26:23]);
            end
            if (j == 0) begin
                n_cmp += 2;
                if (tx_1_o !== W1_D) begin n_bad++; $display("FAIL pixmap w1: got %h want %h", tx_1_o, W1_D); end
                if (tx_2_o !== W2_D) begin n_bad++; $display("FAIL pixmap w2: got %h want %h", tx_2_o, W2_D); end
            end
        end
        pixel_data_i = D0;
    endtask

    task automatic test_underrun();
        logic [27:0] e1;
        pixel_data_i = D0;
        wait_fs("underrun");
        for (int i = 1; i <= 23; i++) begin
            pixel_vld_i = !(i >= 5 && i <= 7);
            @(negedge sys_clk);
            if (i <= 11) begin
                if (i <= 2 || i >= 10) e1 = W_HB;
                else if (i >= 5 && i <= 7) e1 = W_UR;
                else e1 = W1_D;
                n_cmp++;
                if (tx_1_o !== e1) begin n_bad++; $display("FAIL underrun tx_1 @%0d: got %h want %h", i, tx_1_o, e1); end
            end
            if (i == 5) begin
                n_cmp++;
                if (pixel_rdy_o !== 1'b1) begin n_bad++; $display("FAIL underrun rdy: got %b want 1", pixel_rdy_o); end
            end
            if (i == 11 || i == 22) begin
                n_cmp++;
                if (underrun_cnt_o !== 16'd3) begin
                    n_bad++; $display("FAIL underrun cnt @%0d: got %0d want 3", i, underrun_cnt_o);
                end
            end
            if (i == 22 || i == 23) begin
                n_cmp++;
                if (frame_start_o !== (i == 23)) begin
                    n_bad++; $display("FAIL underrun fs @%0d: got %b want %b", i, frame_start_o, i == 23);
                end
            end
        end
        n_cmp++;
        if (underrun_cnt_o !== 16'd0) begin n_bad++; $display("FAIL underrun clear: got %0d want 0", underrun_cnt_o); end
        pixel_vld_i = 1'b1;
    endtask

    task automatic test_enable_drop();
        logic [27:0] e1;
        for (int i = 1; i <= 26; i++) begin
            enable_i = (i < 8);
            @(negedge sys_clk);
            if (i <= 20) begin
                case (state_of(i))
                    1:       e1 = W_HB;
                    2:       e1 = W1_D;
                    default: e1 = W_ZERO;
                endcase
            end else begin
                e1 = W_ZERO;
            end
            n_cmp += 2;
            if (tx_1_o !== e1) begin n_bad++; $display("FAIL endrop tx_1 @%0d: got %h want %h", i, tx_1_o, e1); end
            if (frame_start_o !== 1'b0) begin n_bad++; $display("FAIL endrop fs @%0d: got %b want 0", i, frame_start_o); end
            if (i > 20) begin
                n_cmp++;
                if (pixel_rdy_o !== 1'b0) begin n_bad++; $display("FAIL endrop rdy @%0d: got %b want 0", i, pixel_rdy_o); end
            end
        end
        enable_i = 1'b1;
        @(negedge sys_clk);
        n_cmp++;
        if (frame_start_o !== 1'b1) begin n_bad++; $display("FAIL reenable fs: got %b want 1", frame_start_o); end
        @(negedge sys_clk);
        n_cmp++;
        if (tx_1_o !== W_HB) begin n_bad++; $display("FAIL reenable tx_1: got %h want %h", tx_1_o, W_HB); end
    endtask

    task automatic test_reset_mid();
        wait_rdy("rstmid");
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (tx_1_o !== W_ZERO) begin n_bad++; $display("FAIL rstmid tx_1: got %h want %h", tx_1_o, W_ZERO); end
        if (tx_2_o !== W_ZERO) begin n_bad++; $display("FAIL rstmid tx_2: got %h want %h", tx_2_o, W_ZERO); end
        if (pixel_rdy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid rdy: got %b want 0", pixel_rdy_o); end
        if (underrun_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rstmid uc: got %0d want 0", underrun_cnt_o); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        n_cmp += 2;
        if (frame_start_o !== 1'b1) begin n_bad++; $display("FAIL rstmid restart fs: got %b want 1", frame_start_o); end
        if (tx_1_o !== W_ZERO) begin n_bad++; $display("FAIL rstmid restart tx_1: got %h want %h", tx_1_o, W_ZERO); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (tx_1_o !== ((i <= 2) ? W_HB : W1_D)) begin
                n_bad++; $display("FAIL rstmid line tx_1 @%0d: got %h want %h", i, tx_1_o, (i <= 2) ? W_HB : W1_D);
            end
        end
    endtask

`ifdef CLINK_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [47:0] ebeat;
        sys_rst_n   = 1'b0;
        enable_i    = 1'b1;
        test_mode_i = 1'b1;
        pixel_vld_i = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_fs("pattern");
        for (int i = 1; i <= 23; i++) begin
            @(negedge sys_clk);
            ebeat = 48'd0;
            if (i == 3) ebeat = {12'h003, 12'h002, 12'h001, 12'h000};
            if (i == 4) ebeat = {12'h007, 12'h006, 12'h005, 12'h004};
            if (i == 9 || i == 23) ebeat = {12'h004, 12'h003, 12'h002, 12'h001};
            if (ebeat != 48'd0) begin
                n_cmp += 3;
                if (rx_px(tx_1_o) !== ebeat[23:0]) begin
                    n_bad++; $display("FAIL pattern ch1 @%0d: got %h want %h", i, rx_px(tx_1_o), ebeat[23:0]);
                end
                if (rx_px(tx_2_o) !== ebeat[47:24]) begin
                    n_bad++; $display("FAIL pattern ch2 @%0d: got %h want %h", i, rx_px(tx_2_o), ebeat[47:24]);
                end
                if (tx_1_o[26] !== 1'b1) begin n_bad++; $display("FAIL pattern dval @%0d: got %b want 1", i, tx_1_o[26]); end
            end
            n_cmp++;
            if (pixel_rdy_o !== 1'b0) begin n_bad++; $display("FAIL pattern rdy @%0d: got %b want 0", i, pixel_rdy_o); end
            if (i == 20) begin
                n_cmp += 2;
                if (frame_start_o !== 1'b1) begin n_bad++; $display("FAIL pattern fs: got %b want 1", frame_start_o); end
                if (underrun_cnt_o !== 16'd0) begin n_bad++; $display("FAIL pattern uc: got %0d want 0", underrun_cnt_o); end
            end
        end
        test_mode_i = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_timing();
        test_pixel_map();
        test_underrun();
        test_enable_drop();
        test_reset_mid();
`ifdef CLINK_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
